// File: rtl/concat_scatter_seq.sv
// concat_scatter_seq: splits one packed word {head, lanes} into a sequence of
// element-addressed field writes (lanes ascending, then head) and keeps shadow
// copies of every field that has been written.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 synchronous abort of the current transaction
//   in_valid/in_ready     input word handshake, in_data = {head, lane[N-1..0]}
//   wr_valid/wr_ready     field write handshake
//   wr_idx, wr_data       field select (NUM_LANES = head) and zero-extended value
//   head_q, lanes_q       shadow copies of the written fields
//   busy                  transaction in progress
//   done                  pulse on the cycle the head write is accepted
module concat_scatter_seq #(
    parameter int unsigned LANE_W    = 2,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned HEAD_W    = 2,
    localparam int unsigned W  = HEAD_W + NUM_LANES * LANE_W,
    localparam int unsigned FW = (LANE_W > HEAD_W) ? LANE_W : HEAD_W,
    localparam int unsigned IW = $clog2(NUM_LANES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W-1:0]                  in_data,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [IW-1:0]                 wr_idx,
    output logic [FW-1:0]                 wr_data,
    output logic [HEAD_W-1:0]             head_q,
    output logic [NUM_LANES*LANE_W-1:0]   lanes_q,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LANE = 2'd1,
        HEAD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [W-1:0]      word;
    logic [IW-1:0]     cnt;
    logic [LANE_W-1:0] lane_val;
    logic [HEAD_W-1:0] head_val;
    logic              last_lane;
    logic              load;
    logic              lane_acc;
    logic              head_acc;

    // Field currently addressed by the lane counter, and the head field.
    assign lane_val  = LANE_W'(word >> (32'(cnt) * LANE_W));
    assign head_val  = word[W-1 -: HEAD_W];
    assign last_lane = (cnt == IW'(NUM_LANES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake/write-port outputs; flush overrides every accept.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_valid  = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        lane_acc  = 1'b0;
        head_acc  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid && !flush;
                if (load) begin
                    state_nxt = LANE;
                end
            end
            LANE: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                wr_idx   = cnt;
                wr_data  = FW'(lane_val);
                lane_acc = wr_ready && !flush;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (lane_acc && last_lane) begin
                    state_nxt = HEAD;
                end
            end
            HEAD: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                wr_idx   = IW'(NUM_LANES);
                wr_data  = FW'(head_val);
                in_ready = wr_ready;
                head_acc = wr_ready && !flush;
                done     = head_acc;
                load     = head_acc && in_valid;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (head_acc) begin
                    state_nxt = in_valid ? LANE : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Captured word and lane counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (load) begin
            word <= in_data;
            cnt  <= '0;
        end else if (flush) begin
            word <= '0;
            cnt  <= '0;
        end else if (lane_acc) begin
            cnt <= last_lane ? '0 : cnt + IW'(1);
        end
    end

    // Shadow fields change only on accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            lanes_q <= '0;
        end else begin
            if (head_acc) begin
                head_q <= head_val;
            end
            if (lane_acc) begin
                for (int i = 0; i < int'(NUM_LANES); i++) begin
                    if (cnt == IW'(i)) begin
                        lanes_q[i*LANE_W +: LANE_W] <= lane_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_concat_scatter_seq.sv
// Directed bench for concat_scatter_seq: default geometry plus a
// LANE_W=3 / NUM_LANES=1 / HEAD_W=5 instance.
module tb_concat_scatter_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_idx;
    logic [1:0]  wr_data;
    logic [1:0]  head_q;
    logic [7:0]  lanes_q;
    logic        busy;
    logic        done;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic        b_wr_valid;
    logic        b_wr_ready;
    logic [0:0]  b_wr_idx;
    logic [4:0]  b_wr_data;
    logic [4:0]  b_head_q;
    logic [2:0]  b_lanes_q;
    logic        b_busy;
    logic        b_done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    concat_scatter_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .head_q   (head_q),
        .lanes_q  (lanes_q),
        .busy     (busy),
        .done     (done)
    );

    concat_scatter_seq #(.LANE_W(3), .NUM_LANES(1), .HEAD_W(5)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .wr_valid (b_wr_valid),
        .wr_ready (b_wr_ready),
        .wr_idx   (b_wr_idx),
        .wr_data  (b_wr_data),
        .head_q   (b_head_q),
        .lanes_q  (b_lanes_q),
        .busy     (b_busy),
        .done     (b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " wr_valid"}, 32'(wr_valid), 32'd0);
        check({tag, " wr_idx"},   32'(wr_idx),   32'd0);
        check({tag, " wr_data"},  32'(wr_data),  32'd0);
        check({tag, " head_q"},   32'(head_q),   32'd0);
        check({tag, " lanes_q"},  32'(lanes_q),  32'd0);
        check({tag, " busy"},     32'(busy),     32'd0);
        check({tag, " done"},     32'(done),     32'd0);
    endtask

    // Hand-computed field sequences: 10'h393 = 11_10_01_00_11, 10'h0FF = 00_11_11_11_11.
    int e393 [5] = '{3, 0, 1, 2, 3};
    int e0ff [5] = '{3, 3, 3, 3, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        wr_ready   = 1'b0;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        b_wr_ready = 1'b0;

        // Reset state.
        #12;
        check_reset_outputs("rst");
        check("rst b_in_ready", 32'(b_in_ready), 32'd1);
        tick();
        rst_n = 1'b1;

        // Single word, wr_ready held high.
        in_valid = 1'b1;
        in_data  = 10'h393;
        wr_ready = 1'b1;
        @(negedge clk);
        check("t1 in_ready idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t1 valid%0d", i), 32'(wr_valid), 32'd1);
            check($sformatf("t1 idx%0d", i),   32'(wr_idx),   32'(i));
            check($sformatf("t1 data%0d", i),  32'(wr_data),  32'(e393[i]));
            check($sformatf("t1 done%0d", i),  32'(done),     32'(i == 4));
            tick();
        end
        @(negedge clk);
        check("t1 lanes_q", 32'(lanes_q), 32'h93);
        check("t1 head_q",  32'(head_q),  32'h3);
        check("t1 busy",    32'(busy),    32'd0);

        // Same word with wr_ready toggling 1,0,1,0...
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        c = 0;
        while (k < 5 && c < 20) begin
            wr_ready = (c % 2 == 0);
            @(negedge clk);
            check($sformatf("t2 valid c%0d", c), 32'(wr_valid), 32'd1);
            check($sformatf("t2 idx c%0d", c),   32'(wr_idx),   32'(k));
            check($sformatf("t2 data c%0d", c),  32'(wr_data),  32'(e393[k]));
            check($sformatf("t2 done c%0d", c),  32'(done),     32'(wr_ready && k == 4));
            if (wr_ready) k++;
            c++;
            tick();
        end
        check("t2 all writes", 32'(k), 32'd5);
        wr_ready = 1'b1;
        @(negedge clk);
        check("t2 lanes_q", 32'(lanes_q), 32'h93);
        check("t2 head_q",  32'(head_q),  32'h3);

        // Back-to-back words with in_valid held.
        in_valid = 1'b1;
        in_data  = 10'h393;
        tick();
        in_data = 10'h0FF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t3a idx%0d", i),  32'(wr_idx),   32'(i));
            check($sformatf("t3a data%0d", i), 32'(wr_data),  32'(e393[i]));
            check($sformatf("t3a rdy%0d", i),  32'(in_ready), 32'(i == 4));
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t3b valid%0d", i), 32'(wr_valid), 32'd1);
            check($sformatf("t3b idx%0d", i),   32'(wr_idx),   32'(i));
            check($sformatf("t3b data%0d", i),  32'(wr_data),  32'(e0ff[i]));
            check($sformatf("t3b done%0d", i),  32'(done),     32'(i == 4));
            tick();
        end
        @(negedge clk);
        check("t3 lanes_q", 32'(lanes_q), 32'hFF);
        check("t3 head_q",  32'(head_q),  32'h0);
        check("t3 busy",    32'(busy),    32'd0);

        // Flush after lanes 0-1 of 10'h393.
        in_valid = 1'b1;
        in_data  = 10'h393;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("t4 idx at flush", 32'(wr_idx), 32'd2);
        check("t4 done at flush", 32'(done), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t4 wr_valid", 32'(wr_valid), 32'd0);
        check("t4 busy",     32'(busy),     32'd0);
        check("t4 in_ready", 32'(in_ready), 32'd1);
        check("t4 done",     32'(done),     32'd0);
        check("t4 lanes_q",  32'(lanes_q),  32'hF3);
        check("t4 head_q",   32'(head_q),   32'h0);

        // Asynchronous reset mid-LANE.
        in_valid = 1'b1;
        in_data  = 10'h0FF;
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t5 pre busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5 in_ready after", 32'(in_ready), 32'd1);
        check("t5 busy after",     32'(busy),     32'd0);

        // Narrow-lane, wide-head instance.
        b_wr_ready = 1'b1;
        b_in_valid = 1'b1;
        b_in_data  = 8'hA5;
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        check("t6 valid0", 32'(b_wr_valid), 32'd1);
        check("t6 idx0",   32'(b_wr_idx),   32'd0);
        check("t6 data0",  32'(b_wr_data),  32'b101);
        check("t6 done0",  32'(b_done),     32'd0);
        tick();
        @(negedge clk);
        check("t6 idx1",   32'(b_wr_idx),   32'd1);
        check("t6 data1",  32'(b_wr_data),  32'b10100);
        check("t6 done1",  32'(b_done),     32'd1);
        tick();
        @(negedge clk);
        check("t6 lanes_q", 32'(b_lanes_q), 32'b101);
        check("t6 head_q",  32'(b_head_q),  32'b10100);
        check("t6 busy",    32'(b_busy),    32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/concat_scatter_seq.md
Name: concat_scatter_seq

Overview:
- Sequencer for a nested-concatenation assignment `{head, lanes} = word`, where `lanes` is a packed array of `NUM_LANES` elements of `LANE_W` bits.
- Accepts one packed word per transaction on a valid/ready input. Issues one field write per cycle on a write port: lanes in ascending index order, then the head field.
- Holds shadow copies of the head and lane fields, so downstream logic sees the assembled result.
- Used wherever a wide bus word is split into an element-addressed register file instead of being written in parallel.

Parameters:
- `LANE_W`, 2, width of one lane element.
- `NUM_LANES`, 4, number of lane elements (at least 1).
- `HEAD_W`, 2, width of the head field, the most-significant part of the word.
- Derived, not overridable: `W = HEAD_W + NUM_LANES*LANE_W`; `FW = max(LANE_W, HEAD_W)`; `IW = $clog2(NUM_LANES+1)`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous abort of the current transaction.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when high together with `in_valid`.
- `in_data`  in  `W`  packed word: `{head, lane[NUM_LANES-1], ..., lane[0]}`.
- `wr_valid`  out  1  field write valid.
- `wr_ready`  in  1  downstream accepts the field write.
- `wr_idx`  out  `IW`  0..`NUM_LANES-1` selects a lane; `NUM_LANES` selects the head.
- `wr_data`  out  `FW`  field value, zero-extended to `FW`.
- `head_q`  out  `HEAD_W`  shadow copy of the head field.
- `lanes_q`  out  `NUM_LANES*LANE_W`  shadow copy of the lanes; lane i occupies bits `[i*LANE_W +: LANE_W]`.
- `busy`  out  1  a transaction is in progress.
- `done`  out  1  one-cycle pulse on the cycle the head write is accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; `in_ready`=1; `wr_valid`=0; `wr_idx`=0; `wr_data`=0; `head_q`=0; `lanes_q`=0; `busy`=0; `done`=0; captured word register = 0.
- States: IDLE, LANE, HEAD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `in_data`, set the lane counter to 0, go to LANE.
- LANE:
  - `wr_valid`=1, `wr_idx`=counter, `wr_data`=captured word bits `[cnt*LANE_W +: LANE_W]`, zero-extended.
  - On `wr_ready`: write that lane into `lanes_q`, then increment the counter.
  - After lane `NUM_LANES-1` is accepted, go to HEAD.
  - While `wr_ready`=0, hold all outputs stable.
- HEAD:
  - `wr_valid`=1, `wr_idx`=`NUM_LANES`, `wr_data`=captured bits `[W-1 -: HEAD_W]`, zero-extended.
  - On `wr_ready`: update `head_q`, pulse `done`.
  - `in_ready`=1 in HEAD as well. If `in_valid` in the same cycle as the head accept, capture the new word and go directly to LANE with counter 0. Otherwise go to IDLE.
- Handshakes:
  - `in_ready` is asserted only in IDLE or in HEAD. In HEAD it is gated by `wr_ready`: `in_ready = idle | (head & wr_ready)`.
  - `in_ready` depends combinationally on `wr_ready` only; `wr_valid` does not depend on `wr_ready`.
  - Once `wr_valid` rises it stays high until accepted, unless `flush` is asserted.
- Latency:
  - First lane write is visible the cycle after input acceptance.
  - Minimum time per word is `NUM_LANES+1` cycles with `wr_ready` held high.
  - Back-to-back words incur no idle cycle.
- `busy`=1 in LANE and HEAD.
- `flush`:
  - In any state, forces IDLE on the next edge, drops `wr_valid`, and discards the captured word.
  - Shadow registers keep the fields already written; no `done` pulse.
  - `flush` has priority over a coincident `wr_ready` accept or input capture.
- Reset mid-transaction clears everything, shadows included.
- Shadow registers change only on accepted writes.

Test Plan:
- Reset, then `in_data`=10'h393 with `wr_ready`=1. Expect writes (idx,data) = (0,3), (1,0), (2,1), (3,2), (4,3) on 5 consecutive cycles. Expect `done` on the 5th, then `lanes_q`=8'h93 and `head_q`=2'b11.
- Same word with `wr_ready` toggling 1,0,1,0,… Expect `wr_idx`/`wr_data` stable through stalls, the same 5 writes in order, and `done` only on the idx-4 accept.
- Back-to-back 10'h393 then 10'h0FF with `in_valid` held. Expect the second word accepted on the head-accept cycle. Expect the idx-0 write (data 3) of the second word on the next cycle, with no bubble. Expect final `lanes_q`=8'hFF and `head_q`=0.
- `flush` after lanes 0–1 of 10'h393, starting from `lanes_q`=8'hFF. Expect `wr_valid`=0 next cycle and state IDLE. Expect `lanes_q`=8'hF3 (lanes 0–1 updated, lanes 2–3 unchanged) and no `done`.
- Assert `rst_n`=0 asynchronously mid-LANE. Expect all outputs to go to their reset values without a clock edge, and `in_ready`=1 after release.
- Parameter sweep `LANE_W`=3, `NUM_LANES`=1, `HEAD_W`=5 with `in_data`=8'hA5. Expect writes (0,3'b101) then (1,5'b10100), and `done` on the 2nd accept.
